// File: rtl/usb_defs.sv
// rtl/usb_defs.sv - shared line-symbol, FSM-state and stuffing constants for the USB receive path
package usb_defs;

    typedef enum logic [1:0] {
        SYM_SE0 = 2'b00,
        SYM_K   = 2'b01,
        SYM_J   = 2'b10,
        SYM_SE1 = 2'b11
    } sym_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOP  = 2'd3
    } state_t;

    localparam logic [2:0] STUFF_LIMIT    = 3'd6;
    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd3;

    function automatic logic is_jk(input sym_t s);
        return (s == SYM_J) || (s == SYM_K);
    endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// rtl/usb_rx_dpll.sv - 4x phase counter that realigns on line edges and samples the D+/D- symbol
module usb_rx_dpll
    import usb_defs::*;
#(
    parameter int SAMPLE_PHASE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic dp,
    input  logic dn,
    input  logic chg,
    output logic strobe,
    output sym_t sample,
    output sym_t sym
);

    localparam logic [1:0] SAMPLE_AT = 2'(SAMPLE_PHASE);

    logic [1:0] phase;
    logic [1:0] phase_eff;

    // An edge counts as phase 0 in its own cycle, so it wins over the natural wrap.
    assign phase_eff = chg ? 2'd0 : phase;
    assign strobe    = (phase_eff == SAMPLE_AT);
    assign sample    = sym_t'({dp, dn});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 2'd0;
            sym   <= SYM_SE0;
        end else begin
            phase <= phase_eff + 2'd1;
            if (strobe) begin
                sym <= sample;
            end
        end
    end

endmodule

// File: rtl/usb_rx_bitdec.sv
// rtl/usb_rx_bitdec.sv - full-speed USB receive bit decoder: NRZI, unstuffing, SYNC/EOP framing, bus reset
module usb_rx_bitdec
    import usb_defs::*;
#(
    parameter int SAMPLE_PHASE = 2,
    parameter int RESET_CYCLES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phy_rx_dp,
    input  logic       phy_rx_dn,
    input  logic       phy_rx_chg,
    input  logic       en,
    output logic [1:0] ll_sym,
    output logic       ll_bit,
    output logic       ll_valid,
    output logic       ll_sop,
    output logic       ll_eop,
    output logic       ll_err,
    output logic       usb_reset
);

    localparam int               RCW     = $clog2(RESET_CYCLES + 1);
    localparam logic [RCW-1:0]   RST_LIM = RCW'(RESET_CYCLES);

    logic strobe;
    sym_t sample;
    sym_t sym;

    usb_rx_dpll #(
        .SAMPLE_PHASE(SAMPLE_PHASE)
    ) u_dpll (
        .clk   (clk),
        .rst   (rst),
        .dp    (phy_rx_dp),
        .dn    (phy_rx_dn),
        .chg   (phy_rx_chg),
        .strobe(strobe),
        .sample(sample),
        .sym   (sym)
    );

    assign ll_sym = sym;

    state_t     state, state_n;
    sym_t       prev, prev_n;
    logic [2:0] zero_cnt, zero_n;
    logic [2:0] ones_cnt, ones_n;
    logic [1:0] se0_cnt, se0_n;
    logic       bit_n, valid_n, sop_n, eop_n, err_n;
    logic       nrzi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prev     <= SYM_J;
            zero_cnt <= 3'd0;
            ones_cnt <= 3'd0;
            se0_cnt  <= 2'd0;
            ll_bit   <= 1'b0;
            ll_valid <= 1'b0;
            ll_sop   <= 1'b0;
            ll_eop   <= 1'b0;
            ll_err   <= 1'b0;
        end else begin
            state    <= state_n;
            prev     <= prev_n;
            zero_cnt <= zero_n;
            ones_cnt <= ones_n;
            se0_cnt  <= se0_n;
            ll_bit   <= bit_n;
            ll_valid <= valid_n;
            ll_sop   <= sop_n;
            ll_eop   <= eop_n;
            ll_err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        prev_n  = prev;
        zero_n  = zero_cnt;
        ones_n  = ones_cnt;
        se0_n   = se0_cnt;
        bit_n   = ll_bit;
        valid_n = 1'b0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        err_n   = 1'b0;
        nrzi    = (sample == prev);

        if (!en) begin
            state_n = IDLE;
            prev_n  = SYM_J;
            ones_n  = 3'd0;
        end else if (strobe) begin
            if (is_jk(sample)) begin
                prev_n = sample;
            end
            case (state)
                IDLE: begin
                    if (sample == SYM_K) begin
                        state_n = SYNC;
                        zero_n  = 3'd1;
                    end
                end
                SYNC: begin
                    if (is_jk(sample)) begin
                        if (!nrzi) begin
                            zero_n = (zero_cnt == 3'd7) ? 3'd7 : zero_cnt + 3'd1;
                        end else if (zero_cnt >= SYNC_MIN_ZEROS) begin
                            // The closing KK of SYNC is already a run of one 1 for stuffing.
                            sop_n   = 1'b1;
                            state_n = DATA;
                            ones_n  = 3'd1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        err_n   = (sample == SYM_SE1);
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    if (is_jk(sample)) begin
                        if (ones_cnt == STUFF_LIMIT) begin
                            if (nrzi) begin
                                err_n   = 1'b1;
                                state_n = IDLE;
                            end else begin
                                ones_n = 3'd0;
                            end
                        end else begin
                            valid_n = 1'b1;
                            bit_n   = nrzi;
                            ones_n  = nrzi ? ones_cnt + 3'd1 : 3'd0;
                        end
                    end else if (sample == SYM_SE0) begin
                        state_n = EOP;
                        se0_n   = 2'd1;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                EOP: begin
                    if (sample == SYM_SE0) begin
                        if (se0_cnt == 2'd2) begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            se0_n = se0_cnt + 2'd1;
                        end
                    end else if (sample == SYM_J) begin
                        eop_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    logic [RCW-1:0] se0_clks;
    logic [RCW-1:0] se0_clks_inc;

    // Bus reset watches the raw line every clk, independent of sampling and of en.
    assign se0_clks_inc = (se0_clks == RST_LIM) ? se0_clks : se0_clks + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            se0_clks  <= '0;
            usb_reset <= 1'b0;
        end else if (!phy_rx_dp && !phy_rx_dn) begin
            se0_clks  <= se0_clks_inc;
            usb_reset <= (se0_clks_inc == RST_LIM);
        end else begin
            se0_clks  <= '0;
            usb_reset <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_rx_bitdec.sv
// tb/tb_usb_rx_bitdec.sv - scoreboard bench for usb_rx_bitdec with directed line-symbol vectors
module tb_usb_rx_bitdec;

    localparam logic [1:0] L_SE0 = 2'b00;
    localparam logic [1:0] L_K   = 2'b01;
    localparam logic [1:0] L_J   = 2'b10;

    localparam int EV_B0  = 0;
    localparam int EV_B1  = 1;
    localparam int EV_SOP = 2;
    localparam int EV_EOP = 3;
    localparam int EV_ERR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       phy_rx_dp;
    logic       phy_rx_dn;
    logic       phy_rx_chg;
    logic       en;
    logic [1:0] ll_sym;
    logic       ll_bit;
    logic       ll_valid;
    logic       ll_sop;
    logic       ll_eop;
    logic       ll_err;
    logic       usb_reset;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_q[$];
    logic [1:0] cur;
    bit         jit_on   = 1'b0;
    bit         jit_sign = 1'b0;
    int         pid_bits[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

    usb_rx_bitdec #(
        .SAMPLE_PHASE(2),
        .RESET_CYCLES(120)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .phy_rx_dp (phy_rx_dp),
        .phy_rx_dn (phy_rx_dn),
        .phy_rx_chg(phy_rx_chg),
        .en        (en),
        .ll_sym    (ll_sym),
        .ll_bit    (ll_bit),
        .ll_valid  (ll_valid),
        .ll_sop    (ll_sop),
        .ll_eop    (ll_eop),
        .ll_err    (ll_err),
        .usb_reset (usb_reset)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every framing/data strobe is matched against the next expected event.
    always @(negedge clk) begin
        int act;
        int nstr;
        if (!rst) begin
            nstr = int'(ll_valid) + int'(ll_sop) + int'(ll_eop) + int'(ll_err);
            if (nstr != 0) begin
                if (nstr > 1)      act = 9;
                else if (ll_valid) act = ll_bit ? EV_B1 : EV_B0;
                else if (ll_sop)   act = EV_SOP;
                else if (ll_eop)   act = EV_EOP;
                else               act = EV_ERR;
                if (exp_q.size() == 0) check("unexpected_event", act, -1);
                else                   check("event", act, exp_q.pop_front());
            end
        end
    end

    // Drive one bit-time symbol; jitter stretches/shrinks only symbols that start with an edge.
    task automatic send_sym(input logic [1:0] s);
        int len;
        len = 4;
        if (s != cur) begin
            phy_rx_chg = 1'b1;
            if (jit_on) begin
                len      = jit_sign ? 5 : 3;
                jit_sign = !jit_sign;
            end
        end
        {phy_rx_dp, phy_rx_dn} = s;
        cur = s;
        repeat (len) begin
            @(posedge clk);
            #1;
            phy_rx_chg = 1'b0;
        end
    endtask

    task automatic tx_raw(input int b);
        if (b != 0) send_sym(cur);
        else        send_sym((cur == L_J) ? L_K : L_J);
    endtask

    task automatic tx_data(input int b);
        exp_q.push_back(b);
        tx_raw(b);
    endtask

    task automatic tx_sync(input bit expect_sop);
        send_sym(L_K); send_sym(L_J); send_sym(L_K); send_sym(L_J);
        send_sym(L_K); send_sym(L_J); send_sym(L_K);
        if (expect_sop) exp_q.push_back(EV_SOP);
        send_sym(L_K);
    endtask

    task automatic tx_eop_ok();
        send_sym(L_SE0);
        send_sym(L_SE0);
        exp_q.push_back(EV_EOP);
        send_sym(L_J);
        repeat (3) send_sym(L_J);
    endtask

    task automatic tx_pid_packet();
        tx_sync(1'b1);
        for (int i = 0; i < 8; i++) tx_data(pid_bits[i]);
        tx_eop_ok();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        phy_rx_chg = 1'b0;
        {phy_rx_dp, phy_rx_dn} = L_J;
        cur        = L_J;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ll_sym", int'(ll_sym), 0);
        check("reset_usb_reset", int'(usb_reset), 0);
        check("reset_strobes", int'(ll_valid) + int'(ll_sop) + int'(ll_eop) + int'(ll_err) + int'(ll_bit), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (4) send_sym(L_J);
        check("idle_sym_j", int'(ll_sym), int'(L_J));

        // SYNC + PID 0x69 + 0xFF 0xFF with two stuff bits + good EOP
        tx_sync(1'b1);
        for (int i = 0; i < 8; i++) tx_data(pid_bits[i]);
        for (int i = 1; i <= 16; i++) begin
            tx_data(1);
            if (i == 6 || i == 12) tx_raw(0);
        end
        tx_eop_ok();

        // seven consecutive ones: six delivered, the seventh is a stuff error
        tx_sync(1'b1);
        tx_data(0);
        repeat (6) tx_data(1);
        exp_q.push_back(EV_ERR);
        tx_raw(1);
        tx_raw(1); tx_raw(0); tx_raw(1); tx_raw(0);
        repeat (3) send_sym(L_J);

        // three SE0 bit-times is a malformed EOP
        tx_sync(1'b1);
        tx_data(1);
        tx_data(0);
        send_sym(L_SE0);
        send_sym(L_SE0);
        exp_q.push_back(EV_ERR);
        send_sym(L_SE0);
        repeat (3) send_sym(L_J);

        // long SE0: bus reset after 120 clk of SE0
        {phy_rx_dp, phy_rx_dn} = L_SE0;
        phy_rx_chg = 1'b1;
        cur = L_SE0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            phy_rx_chg = 1'b0;
            if (k == 50)  check("se0_sym", int'(ll_sym), int'(L_SE0));
            if (k == 118) check("usb_reset_before", int'(usb_reset), 0);
            if (k == 121) check("usb_reset_after", int'(usb_reset), 1);
            if (k == 200) check("usb_reset_held", int'(usb_reset), 1);
        end
        {phy_rx_dp, phy_rx_dn} = L_J;
        phy_rx_chg = 1'b1;
        cur = L_J;
        @(posedge clk);
        #1;
        phy_rx_chg = 1'b0;
        check("usb_reset_release", int'(usb_reset), 0);
        repeat (3) send_sym(L_J);

        // receiver disabled: symbols tracked, no strobes
        en = 1'b0;
        tx_sync(1'b0);
        check("disabled_sym_k", int'(ll_sym), int'(L_K));
        tx_raw(1); tx_raw(0); tx_raw(0);
        repeat (3) send_sym(L_J);
        en = 1'b1;
        repeat (2) send_sym(L_J);

        // same packet with every edge moved by +/-1 clk
        jit_on = 1'b1;
        tx_pid_packet();
        jit_on = 1'b0;

        // async reset in the middle of SYNC drops everything
        send_sym(L_K); send_sym(L_J); send_sym(L_K);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_sym", int'(ll_sym), 0);
        check("async_rst_strobes", int'(ll_valid) + int'(ll_sop) + int'(ll_eop) + int'(ll_err), 0);
        repeat (2) @(posedge clk);
        #1;
        {phy_rx_dp, phy_rx_dn} = L_J;
        phy_rx_chg = 1'b1;
        cur = L_J;
        rst = 1'b0;
        repeat (3) send_sym(L_J);
        tx_pid_packet();

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
